// File: rtl/ppu_pkg.sv
// Shared types and constants for the posit processing unit and its issue front end.
package ppu_pkg;

    localparam int N        = 16;
    localparam int ES       = 1;
    localparam int OP_BITS  = 3;
    localparam int MAX_ID_W = 4;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_FMADD,
        OP_F2P,
        OP_P2F
    } operation_e;

    // The op is carried as raw bits so the issue path never has to decode it.
    typedef struct packed {
        logic [OP_BITS-1:0] op;
        logic [N-1:0]       operand1;
        logic [N-1:0]       operand2;
        logic [N-1:0]       operand3;
    } ppu_req_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } ppu_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester found
// when scanning upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppu_issue_arbiter.sv
// Shares one fixed-latency PPU core between NREQ requesters: round-robin issue,
// requester-ID tag pipeline matched to the core latency, and result routing.
import ppu_pkg::*;

module ppu_issue_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0][OP_BITS-1:0]   req_op,
    input  logic [NREQ-1:0][N-1:0]         req_operand1,
    input  logic [NREQ-1:0][N-1:0]         req_operand2,
    input  logic [NREQ-1:0][N-1:0]         req_operand3,
    output logic                           core_in_valid,
    input  logic                           core_in_ready,
    output logic [OP_BITS-1:0]             core_op,
    output logic [N-1:0]                   core_operand1,
    output logic [N-1:0]                   core_operand2,
    output logic [N-1:0]                   core_operand3,
    input  logic                           core_out_valid,
    input  logic [N-1:0]                   core_out_result,
    output logic [NREQ-1:0]                res_valid,
    output logic [N-1:0]                   res_data,
    output logic                           tag_error
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [NREQ-1:0]  arb_grant;
    logic [ID_W-1:0]  win_id;
    logic             win_any;
    logic             issue_free;
    logic             xfer;
    logic             core_hs;
    ppu_req_t         issue_q;
    logic [ID_W-1:0]  issue_id;
    ppu_tag_t         tag_last;
    logic [CNT_W-1:0] flush_cnt;
    logic             flush_done;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .grant_id (win_id),
        .any      (win_any)
    );

    assign issue_free = !core_in_valid || core_in_ready;
    assign req_ready  = issue_free ? arb_grant : '0;
    assign xfer       = issue_free && win_any;
    assign core_hs    = core_in_valid && core_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in_valid <= 1'b0;
            issue_q       <= '0;
            issue_id      <= '0;
            rr_ptr        <= '0;
        end else if (xfer) begin
            core_in_valid     <= 1'b1;
            issue_q.op        <= req_op[win_id];
            issue_q.operand1  <= req_operand1[win_id];
            issue_q.operand2  <= req_operand2[win_id];
            issue_q.operand3  <= req_operand3[win_id];
            issue_id          <= win_id;
            rr_ptr            <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
        end else if (core_in_ready) begin
            core_in_valid <= 1'b0;
        end
    end

    assign core_op       = issue_q.op;
    assign core_operand1 = issue_q.operand1;
    assign core_operand2 = issue_q.operand2;
    assign core_operand3 = issue_q.operand3;

    generate
        for (genvar s = 0; s < LATENCY; s++) begin : g_tag
            ppu_tag_t tag_q;
            if (s == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) tag_q <= '0;
                    else        tag_q <= '{valid: core_hs, id: MAX_ID_W'(issue_id)};
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) tag_q <= '0;
                    else        tag_q <= g_tag[s-1].tag_q;
                end
            end
        end
    endgenerate

    assign tag_last = g_tag[LATENCY-1].tag_q;

    // Results for ops issued before a reset can still drain from the core for
    // LATENCY cycles after release; the tags for them are gone, so suppress the
    // mismatch check until that window has passed.
    assign flush_done = (flush_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            res_data  <= '0;
            tag_error <= 1'b0;
            flush_cnt <= CNT_W'(LATENCY);
        end else begin
            if (!flush_done) flush_cnt <= flush_cnt - 1'b1;
            res_valid <= '0;
            if (core_out_valid && tag_last.valid) begin
                res_valid <= NREQ'(1) << tag_last.id;
                res_data  <= core_out_result;
            end
            if (flush_done && (core_out_valid != tag_last.valid)) tag_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_issue_arbiter.sv
// Directed bench for ppu_issue_arbiter with a fixed-latency core model.
module tb_ppu_issue_arbiter;
    import ppu_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic                         clk   = 1'b0;
    logic                         rst_n = 1'b1;
    logic [NREQ-1:0]              req_valid = '0;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0][OP_BITS-1:0] req_op = '0;
    logic [NREQ-1:0][N-1:0]       req_a  = '0;
    logic [NREQ-1:0][N-1:0]       req_b  = '0;
    logic [NREQ-1:0][N-1:0]       req_c  = '0;
    logic                         core_in_valid;
    logic                         core_in_ready = 1'b1;
    logic [OP_BITS-1:0]           core_op;
    logic [N-1:0]                 core_operand1, core_operand2, core_operand3;
    logic                         core_out_valid;
    logic [N-1:0]                 core_out_result;
    logic [NREQ-1:0]              res_valid;
    logic [N-1:0]                 res_data;
    logic                         tag_error;
    logic                         inject = 1'b0;
    logic [LAT-1:0]               cm_v  = '0;
    logic [N-1:0]                 cm_d0 = '0, cm_d1 = '0, cm_d2 = '0;
    int                           n_vec = 0;
    int                           n_err = 0;

    ppu_issue_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_operand1    (req_a),
        .req_operand2    (req_b),
        .req_operand3    (req_c),
        .core_in_valid   (core_in_valid),
        .core_in_ready   (core_in_ready),
        .core_op         (core_op),
        .core_operand1   (core_operand1),
        .core_operand2   (core_operand2),
        .core_operand3   (core_operand3),
        .core_out_valid  (core_out_valid),
        .core_out_result (core_out_result),
        .res_valid       (res_valid),
        .res_data        (res_data),
        .tag_error       (tag_error)
    );

    always #5 clk = ~clk;

    // Core stand-in: 1.0 + 1.0 gives posit 2.0, anything else a simple mix of the inputs.
    function automatic logic [N-1:0] core_f(input logic [OP_BITS-1:0] op,
                                            input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] c);
        if (op == 3'd0 && a == 16'h4000 && b == 16'h4000) return 16'h5000;
        return a ^ b ^ c ^ N'(op);
    endfunction

    // Not reset by rst_n, so ops in flight at a reset still emerge afterwards.
    always @(posedge clk) begin
        cm_v  <= {cm_v[LAT-2:0], core_in_valid & core_in_ready};
        cm_d0 <= core_f(core_op, core_operand1, core_operand2, core_operand3);
        cm_d1 <= cm_d0;
        cm_d2 <= cm_d1;
    end

    assign core_out_valid  = cm_v[LAT-1] | inject;
    assign core_out_result = inject ? 16'hDEAD : cm_d2;

    function automatic logic [N-1:0] fair_res(input int i);
        case (i)
            0:       return 16'h1101;
            1:       return 16'h2203;
            2:       return 16'h3406;
            default: return 16'h480B;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fair();
        for (int i = 0; i < NREQ; i++) begin
            req_op[i] = 3'(i);
            req_a[i]  = 16'((i + 1) << 12);
            req_b[i]  = 16'(1 << i);
            req_c[i]  = 16'(32'h100 << i);
        end
    endtask

    initial begin
        // reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_core_in_valid", 16'(core_in_valid), 16'h0);
        chk("rst_res_valid",     16'(res_valid),     16'h0);
        chk("rst_tag_error",     16'(tag_error),     16'h0);
        chk("rst_res_data",      res_data,           16'h0);
        chk("rst_operand1",      core_operand1,      16'h0);
        chk("rst_req_ready",     16'(req_ready),     16'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) step();

        // single ADD from requester 2
        set_fair();
        req_op[2] = 3'd0; req_a[2] = 16'h4000; req_b[2] = 16'h4000; req_c[2] = 16'h0000;
        req_valid = 4'b0100;
        #1 chk("add_req_ready", 16'(req_ready), 16'h0004);
        step();
        req_valid = '0;
        chk("add_core_in_valid", 16'(core_in_valid), 16'h1);
        chk("add_core_op",       16'(core_op),       16'h0);
        chk("add_operand1",      core_operand1,      16'h4000);
        chk("add_operand2",      core_operand2,      16'h4000);
        chk("add_operand3",      core_operand3,      16'h0000);
        for (int j = 1; j <= 4; j++) begin
            step();
            if (j == 1) chk("add_issue_drain", 16'(core_in_valid), 16'h0);
            if (j < 4) chk("add_res_early", 16'(res_valid), 16'h0);
        end
        chk("add_res_valid", 16'(res_valid), 16'h0004);
        chk("add_res_data",  res_data,       16'h5000);
        step();
        chk("add_res_pulse", 16'(res_valid), 16'h0);
        chk("add_res_hold",  res_data,       16'h5000);

        // fairness: all four valid for eight cycles from reset
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) step();
        set_fair();
        for (int j = 0; j < 12; j++) begin
            req_valid = (j < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (j < 8) chk("fair_grant", 16'(req_ready), 16'(1 << (j % 4)));
            step();
            if (j < 8) chk("fair_operand1", core_operand1, 16'(((j % 4) + 1) << 12));
            if (j >= 4) begin
                chk("fair_res_valid", 16'(res_valid), 16'(1 << ((j - 4) % 4)));
                chk("fair_res_data",  res_data,       fair_res((j - 4) % 4));
            end else begin
                chk("fair_res_idle", 16'(res_valid), 16'h0);
            end
        end
        req_valid = '0;

        // core stall with requester 2 waiting behind requester 1
        req_valid = 4'b0010;
        #1 chk("stall_grant1", 16'(req_ready), 16'h0002);
        step();
        core_in_ready = 1'b0;
        req_valid     = 4'b0100;
        #1 chk("stall_ready_low", 16'(req_ready), 16'h0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("stall_valid",    16'(core_in_valid), 16'h1);
            chk("stall_op",       16'(core_op),       16'h1);
            chk("stall_operand1", core_operand1,      16'h2000);
            chk("stall_operand2", core_operand2,      16'h0002);
            chk("stall_ready",    16'(req_ready),     16'h0);
            chk("stall_res",      16'(res_valid),     16'h0);
        end
        core_in_ready = 1'b1;
        #1 chk("stall_grant2", 16'(req_ready), 16'h0004);
        step();
        req_valid = '0;
        chk("stall_next_operand1", core_operand1, 16'h3000);
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 3) begin
                chk("stall_res1_valid", 16'(res_valid), 16'h0002);
                chk("stall_res1_data",  res_data,       16'h2203);
            end else if (j == 4) begin
                chk("stall_res2_valid", 16'(res_valid), 16'h0004);
                chk("stall_res2_data",  res_data,       16'h3406);
            end else begin
                chk("stall_res_idle", 16'(res_valid), 16'h0);
            end
        end

        // reset with three ops in the tag pipeline
        req_valid = 4'b1111;
        #1 chk("mid_grant3", 16'(req_ready), 16'h0008);
        step();
        chk("mid_grant0", 16'(req_ready), 16'h0001);
        step();
        chk("mid_grant1", 16'(req_ready), 16'h0002);
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        #2;
        chk("mid_core_in_valid", 16'(core_in_valid), 16'h0);
        chk("mid_operand1",      core_operand1,      16'h0);
        chk("mid_res_valid",     16'(res_valid),     16'h0);
        chk("mid_res_data",      res_data,           16'h0);
        chk("mid_tag_error",     16'(tag_error),     16'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("mid_stray_res",   16'(res_valid), 16'h0);
            chk("mid_stray_error", 16'(tag_error), 16'h0);
        end
        chk("mid_stray_data", res_data, 16'h0);

        // pointer wrap 3 -> 0
        req_valid = 4'b1000;
        #1 chk("wrap_grant3", 16'(req_ready), 16'h0008);
        step();
        req_valid = 4'b1001;
        #1 chk("wrap_grant0", 16'(req_ready), 16'h0001);
        step();
        chk("wrap_next", 16'(req_ready), 16'h0008);
        req_valid = '0;
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 3) begin
                chk("wrap_res3_valid", 16'(res_valid), 16'h0008);
                chk("wrap_res3_data",  res_data,       16'h480B);
            end else if (j == 4) begin
                chk("wrap_res0_valid", 16'(res_valid), 16'h0001);
                chk("wrap_res0_data",  res_data,       16'h1101);
            end else begin
                chk("wrap_res_idle", 16'(res_valid), 16'h0);
            end
            chk("wrap_tag_error", 16'(tag_error), 16'h0);
        end

        // stray result with no matching tag
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("mis_tag_error", 16'(tag_error), 16'h1);
        chk("mis_res_valid", 16'(res_valid), 16'h0);
        chk("mis_res_data",  res_data,       16'h1101);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("mis_sticky", 16'(tag_error), 16'h1);
            chk("mis_no_res", 16'(res_valid), 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
